// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and writes them sequentially into instruction memory.
// Optional macro ENC_RANGE_CHECK_EN drops tuples whose immediate overflows its field and raises range_err.
module instr_encoder_loader #(
  parameter int BUS    = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [1:0]        funtype,
  input  logic [1:0]        funcode,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs,
  input  logic [3:0]        rx,
  input  logic [BUS-1:0]    imm_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              full,
  output logic              range_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       packed_word;
  logic              overflow, accept, drop, write, base_oob, at_last;

  // Handshake: a tuple transfers on a cycle where in_valid and in_ready are
  // both high; in_ready is a function of state and start only.
  assign in_ready = (state == S_RUN) && !start;
  assign accept   = in_valid && in_ready;
  assign drop     = accept && overflow && RANGE_CHECK;
  assign write    = accept && !drop;
  assign base_oob = {1'b0, base_addr} >= (ADDR_W+1)'(DEPTH);
  assign at_last  = cur_addr == ADDR_W'(DEPTH - 1);
  assign busy     = state == S_RUN;
  assign full     = state == S_FULL;

  always_comb begin
    packed_word = '0;
    overflow    = 1'b0;
    case (fmt)
      2'b00: packed_word = {funtype, funcode, rd, rs, rx, 15'b0, 1'b0};
      2'b01: begin
        packed_word = {funtype, funcode, rd, rs, imm_in[18:0], 1'b1};
        overflow    = (imm_in >> 19) != '0;
      end
      2'b10: begin
        packed_word = {funtype, funcode, rd, imm_in[3:0], rx, 15'b0, 1'b1};
        overflow    = (imm_in >> 4) != '0;
      end
      default: begin
        packed_word = {funtype, funcode, imm_in[27:0]};
        overflow    = (imm_in >> 28) != '0;
      end
    endcase
  end

  // finish outranks the last-address FULL transition: the word still lands.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = base_oob ? S_FULL : S_RUN;
      S_RUN: begin
        if (start)                 state_nxt = base_oob ? S_FULL : S_RUN;
        else if (finish)           state_nxt = S_IDLE;
        else if (write && at_last) state_nxt = S_FULL;
      end
      S_FULL: begin
        if (start)       state_nxt = base_oob ? S_FULL : S_RUN;
        else if (finish) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      range_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= write;
      if (write) begin
        mem_addr  <= cur_addr;
        mem_wdata <= packed_word;
      end
      if (start) begin
        cur_addr   <= base_addr;
        word_count <= '0;
        range_err  <= 1'b0;
      end else begin
        if (write) begin
          cur_addr   <= cur_addr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        if (drop) range_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default instance plus a DEPTH=4 instance for fill tests.
module tb_instr_encoder_loader;

  logic        clk, rst, start, finish, in_valid;
  logic [9:0]  base_addr;
  logic [1:0]  fmt, funtype, funcode;
  logic [3:0]  rd, rs, rx;
  logic [31:0] imm_in;

  logic        in_ready, mem_we, busy, full, range_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] word_count;

  logic        s_in_ready, s_mem_we, s_busy, s_full, s_range_err;
  logic [2:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [3:0]  s_word_count;

  int checks = 0;
  int failures = 0;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .funtype(funtype),
    .funcode(funcode), .rd(rd), .rs(rs), .rx(rx), .imm_in(imm_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .busy(busy), .full(full), .range_err(range_err)
  );

  instr_encoder_loader #(.BUS(32), .ADDR_W(3), .DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[2:0]), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .fmt(fmt), .funtype(funtype),
    .funcode(funcode), .rd(rd), .rs(rs), .rx(rx), .imm_in(imm_in),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .word_count(s_word_count), .busy(s_busy), .full(s_full), .range_err(s_range_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; finish = 0; in_valid = 0; base_addr = '0;
    fmt = 0; funtype = 0; funcode = 0; rd = 0; rs = 0; rx = 0; imm_in = '0;
  endtask

  task automatic do_start(input logic [9:0] base);
    start = 1; base_addr = base;
    tick();
    start = 0;
  endtask

  task automatic set_tuple(input logic [1:0] f, input logic [1:0] ft, input logic [1:0] fc,
                           input logic [3:0] d, input logic [3:0] s, input logic [3:0] x,
                           input logic [31:0] imm);
    fmt = f; funtype = ft; funcode = fc; rd = d; rs = s; rx = x; imm_in = imm;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    tick();
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 || word_count !== 11'd0 ||
        busy !== 1'b0 || full !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset: we=%b addr=%h wdata=%h cnt=%0d busy=%b full=%b rerr=%b rdy=%b expected all 0",
               mem_we, mem_addr, mem_wdata, word_count, busy, full, range_err, in_ready);
    end
    rst = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_reg();
    do_start(10'd0);
    set_tuple(2'b00, 2'b01, 2'b10, 4'd3, 4'd4, 4'd5, 32'h0);
    in_valid = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reg_ready: rdy=%b busy=%b expected 1 1", in_ready, busy);
    end
    tick();
    in_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h63450000 || word_count !== 11'd1) begin
      failures++;
      $display("FAIL reg_write: we=%b addr=%h wdata=%h cnt=%0d expected 1 000 63450000 1",
               mem_we, mem_addr, mem_wdata, word_count);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reg_we_drop: we=%b expected 0", mem_we);
    end
  endtask

  task automatic test_back_to_back();
    do_start(10'h010);
    in_valid = 1;
    set_tuple(2'b01, 2'b00, 2'b01, 4'h1, 4'h2, 4'h0, 32'h0007FFFF);
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 32'h112FFFFF) begin
      failures++;
      $display("FAIL b2b_imm19: we=%b addr=%h wdata=%h expected 1 010 112fffff", mem_we, mem_addr, mem_wdata);
    end
    set_tuple(2'b10, 2'b10, 2'b00, 4'hA, 4'h0, 4'h2, 32'h0000000F);
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'h011 || mem_wdata !== 32'h8AF20001) begin
      failures++;
      $display("FAIL b2b_imm4: we=%b addr=%h wdata=%h expected 1 011 8af20001", mem_we, mem_addr, mem_wdata);
    end
    set_tuple(2'b11, 2'b11, 2'b11, 4'h0, 4'h0, 4'h0, 32'h00ABCDEF);
    tick();
    in_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'h012 || mem_wdata !== 32'hF0ABCDEF || word_count !== 11'd3) begin
      failures++;
      $display("FAIL b2b_imm28: we=%b addr=%h wdata=%h cnt=%0d expected 1 012 f0abcdef 3",
               mem_we, mem_addr, mem_wdata, word_count);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_we;
    logic [2:0] exp_addr [4];
    exp_we = 4'b0011;
    exp_addr[0] = 3'd2; exp_addr[1] = 3'd3; exp_addr[2] = 3'd3; exp_addr[3] = 3'd3;
    do_start(10'd2);
    set_tuple(2'b00, 2'b01, 2'b01, 4'd1, 4'd1, 4'd1, 32'h0);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_mem_we !== exp_we[i] || (exp_we[i] && s_mem_addr !== exp_addr[i])) begin
        failures++;
        $display("FAIL fill_write%0d: we=%b addr=%0d expected %b %0d", i, s_mem_we, s_mem_addr, exp_we[i], exp_addr[i]);
      end
      if (i >= 1) begin
        checks++;
        if (s_full !== 1'b1 || s_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL fill_full%0d: full=%b rdy=%b expected 1 0", i, s_full, s_in_ready);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (s_word_count !== 4'd2) begin
      failures++;
      $display("FAIL fill_count: cnt=%0d expected 2", s_word_count);
    end
    finish = 1;
    tick();
    finish = 0;
    checks++;
    if (s_busy !== 1'b0 || s_full !== 1'b0) begin
      failures++;
      $display("FAIL fill_finish: busy=%b full=%b expected 0 0", s_busy, s_full);
    end
    // base beyond the memory goes straight to FULL
    do_start(10'd5);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if (s_full !== 1'b1 || s_busy !== 1'b0 || s_mem_we !== 1'b0 || s_word_count !== 4'd0) begin
      failures++;
      $display("FAIL fill_oob: full=%b busy=%b we=%b cnt=%0d expected 1 0 0 0", s_full, s_busy, s_mem_we, s_word_count);
    end
    finish = 1;
    tick();
    finish = 0;
  endtask

  task automatic test_range();
    do_start(10'd0);
    set_tuple(2'b10, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 32'h00000010);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
`ifdef ENC_RANGE_CHECK_EN
    if (mem_we !== 1'b0 || range_err !== 1'b1 || word_count !== 11'd0) begin
      failures++;
      $display("FAIL range_drop: we=%b rerr=%b cnt=%0d expected 0 1 0", mem_we, range_err, word_count);
    end
    tick();
    do_start(10'd0);
    checks++;
    if (range_err !== 1'b0) begin
      failures++;
      $display("FAIL range_clear: rerr=%b expected 0", range_err);
    end
`else
    if (mem_we !== 1'b1 || mem_wdata !== 32'h00000001 || range_err !== 1'b0 || word_count !== 11'd1) begin
      failures++;
      $display("FAIL range_trunc: we=%b wdata=%h rerr=%b cnt=%0d expected 1 00000001 0 1",
               mem_we, mem_wdata, range_err, word_count);
    end
`endif
  endtask

  task automatic test_collisions();
    do_start(10'd0);
    set_tuple(2'b00, 2'b11, 2'b00, 4'd7, 4'd8, 4'd9, 32'h0);
    start = 1; in_valid = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL coll_start_ready: rdy=%b expected 0", in_ready);
    end
    tick();
    start = 0;
    checks++;
    if (mem_we !== 1'b0 || word_count !== 11'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL coll_start: we=%b cnt=%0d busy=%b expected 0 0 1", mem_we, word_count, busy);
    end
    finish = 1;
    tick();
    finish = 0; in_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hC7890000 || word_count !== 11'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL coll_finish: we=%b wdata=%h cnt=%0d busy=%b expected 1 c7890000 1 0",
               mem_we, mem_wdata, word_count, busy);
    end
    start = 1; finish = 1;
    tick();
    start = 0; finish = 0;
    checks++;
    if (busy !== 1'b1 || word_count !== 11'd0) begin
      failures++;
      $display("FAIL coll_start_finish: busy=%b cnt=%0d expected 1 0", busy, word_count);
    end
  endtask

  task automatic test_reset_midstream();
    do_start(10'd7);
    set_tuple(2'b00, 2'b01, 2'b01, 4'd1, 4'd2, 4'd3, 32'h0);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd7) begin
      failures++;
      $display("FAIL mid_pre: we=%b addr=%0d expected 1 7", mem_we, mem_addr);
    end
    rst = 1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 10'd0 || word_count !== 11'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: we=%b addr=%0d cnt=%0d busy=%b expected 0 0 0 0", mem_we, mem_addr, word_count, busy);
    end
    tick();
    rst = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle: busy=%b rdy=%b we=%b expected 0 0 0", busy, in_ready, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_reg();
    test_back_to_back();
    test_fill();
    test_range();
    test_collisions();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder for the processor's 32-bit instruction format.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into the 32-bit word the instruction decoder unpacks.
- Writes packed words sequentially into instruction memory from a programmable base word address.
- Used by the program loader/self-test path to build programs in instruction memory at runtime.

Parameters:
BUS, 32, width of the immediate input bus (imm_in)
ADDR_W, 10, instruction memory word-address width
DEPTH, 1024, number of instruction memory words (must be <= 2**ADDR_W)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  pulse: load base_addr, clear word_count, enter RUN
base_addr  input  ADDR_W  first word address written after start
finish  input  1  pulse: return to IDLE
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept a tuple this cycle
fmt  input  2  format: 00 REG, 01 IMM19, 10 IMM4, 11 IMM28
funtype  input  2  function type, packed to bits [31:30]
funcode  input  2  function code, packed to bits [29:28]
rd  input  4  destination register, packed to bits [27:24]
rs  input  4  source register, packed to bits [23:20]
rx  input  4  second source register, packed to bits [19:16]
imm_in  input  BUS  immediate, zero-extended source value
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  packed instruction
word_count  output  ADDR_W+1  words written since last start
busy  output  1  state is RUN
full  output  1  state is FULL
range_err  output  1  sticky immediate-overflow flag (see Optional Feature)

Behaviour:
- Reset (async, active-high): state IDLE; mem_we 0; mem_addr 0; mem_wdata 0; word_count 0; range_err 0; busy 0; full 0.
  - A write pending at reset assertion is dropped.
- States:
  - IDLE: in_ready 0. start -> RUN.
  - RUN: in_ready = ~start. Accept when in_valid & in_ready.
  - FULL: in_ready 0. start -> RUN; finish -> IDLE.
- Packing (word written by an accept):
  - REG: {funtype, funcode, rd, rs, rx, 15'b0, 1'b0}.
  - IMM19: {funtype, funcode, rd, rs, imm_in[18:0], 1'b1}.
  - IMM4: {funtype, funcode, rd, imm_in[3:0], rx, 15'b0, 1'b1}; imm4 occupies the RS field.
  - IMM28: {funtype, funcode, imm_in[27:0]}; bit 0 is imm_in[0].
- Latency: one cycle.
  - Accept at edge N registers mem_we=1, mem_addr=current address, mem_wdata=packed word.
  - These are valid for the cycle after edge N; memory captures at edge N+1.
  - mem_we is 0 in every cycle without an accept at the preceding edge.
- Address and count, on each accept:
  - Write address increments by 1; word_count increments by 1.
  - The write address never wraps: accepting at address DEPTH-1 moves to FULL on the same edge, so in_ready is 0 from the next cycle.
- start:
  - Loads base_addr, clears word_count, clears range_err, enters RUN.
  - Same-cycle start and in_valid in RUN: start wins, tuple not accepted.
  - base_addr >= DEPTH: go directly to FULL, no writes.
- finish in RUN: -> IDLE.
  - Same-cycle finish and accept: the word is written, then IDLE.
  - finish in IDLE: ignored.
- Same-cycle start and finish: start wins.
- in_ready depends only on state and start, never on in_valid.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined:
  - A tuple whose imm_in has nonzero bits above its field width is accepted (handshake completes) but not written. Field widths: IMM19 19 bits, IMM4 4 bits, IMM28 28 bits; REG is never checked.
  - On such a tuple: mem_we stays 0, address and word_count are unchanged, range_err sets and holds until start or rst.
- Undefined:
  - imm_in is silently truncated to the field width and written.
  - range_err is tied to 0.

Test Plan:
- REG: funtype 01, funcode 10, rd 3, rs 4, rx 5, base 0 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x63450000.
- Streamed back-to-back, in_valid held 1, base 0x10:
  - IMM19 (00,01,rd 1,rs 2,imm 0x7FFFF) -> 0x112FFFFF @0x10.
  - IMM4 (10,00,rd A,imm 0xF,rx 2) -> 0x8AF20001 @0x11.
  - IMM28 (11,11,imm 0x0ABCDEF) -> 0xF0ABCDEF @0x12.
  - word_count ends at 3.
- Fill: DEPTH=4, base 2, four tuples offered -> writes at 2 and 3 only; full=1 and in_ready=0 from the cycle after the second accept; word_count=2; then finish -> IDLE, busy=0.
- Range: IMM4 with imm 0x10.
  - With ENC_RANGE_CHECK_EN: no mem_we, range_err=1, word_count unchanged.
  - Without: 0x...0001 word with imm4 field 0 written.
- Collisions:
  - start with in_valid in RUN -> no write, word_count=0.
  - finish with an accept -> that word written, then IDLE.
- Reset mid-stream: rst asserted while mem_we=1 -> mem_we, mem_addr, word_count 0 immediately (asynchronously); state IDLE after release.
